// File: rtl/alu_bist_seq.sv
// Built-in self-test sequencer for the 4-bit ALU: sweeps every opcode/operand
// pair, compares alu_out against a golden model and records the first failure.
//
// state | meaning
// IDLE  | waiting for start after reset
// APPLY | operands driven, waiting SETTLE cycles for alu_out to settle
// CHECK | alu_out compared, vector advanced
// DONE  | sweep finished, pass/err_count/fail_* valid
module alu_bist_seq #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int ERRW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_signal,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [2:0]       fail_signal,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [3:0]       SETTLE_TC = 4'(SETTLE - 1);
  localparam logic [WIDTH-1:0] OPND_MAX  = '1;
  localparam logic [ERRW-1:0]  ERR_MAX   = '1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       settle_cnt;
  logic             load, check, cnt_inc, cnt_clr;
  logic [WIDTH-1:0] golden;
  logic             mismatch, last_vec;

  function automatic logic [2:0] next_op(input logic [2:0] op);
    case (op)
      OP_AND:  next_op = OP_OR;
      OP_OR:   next_op = OP_ADD;
      OP_ADD:  next_op = OP_SUB;
      OP_SUB:  next_op = OP_SLT;
      default: next_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    golden = '0;
    case (alu_signal)
      OP_AND:  golden = alu_a & alu_b;
      OP_OR:   golden = alu_a | alu_b;
      OP_ADD:  golden = alu_a + alu_b;
      OP_SUB:  golden = alu_a - alu_b;
      OP_SLT:  golden = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: golden = '0;
    endcase
  end

  assign mismatch = (alu_out != golden);
  assign last_vec = (alu_signal == OP_SLT) && (alu_a == OPND_MAX) && (alu_b == OPND_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    check     = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = APPLY;
          load      = 1'b1;
        end
      end
      APPLY: begin
        if (settle_cnt == SETTLE_TC) begin
          state_nxt = CHECK;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      CHECK: begin
        check     = 1'b1;
        state_nxt = last_vec ? DONE : APPLY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_signal  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_signal <= '0;
      fail_a      <= '0;
      fail_b      <= '0;
    end else begin
      if (load || cnt_clr) settle_cnt <= '0;
      else if (cnt_inc)    settle_cnt <= settle_cnt + 4'd1;

      if (load) begin
        alu_signal  <= OP_AND;
        alu_a       <= '0;
        alu_b       <= '0;
        err_count   <= '0;
        fail_signal <= '0;
        fail_a      <= '0;
        fail_b      <= '0;
        busy        <= 1'b1;
        done        <= 1'b0;
        pass        <= 1'b0;
      end

      if (check) begin
        if (mismatch) begin
          if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
          // A zero count means nothing has failed yet, since it never wraps
          if (err_count == '0) begin
            fail_signal <= alu_signal;
            fail_a      <= alu_a;
            fail_b      <= alu_b;
          end
        end
        if (last_vec) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_count == '0) && !mismatch;
        end else begin
          alu_b <= alu_b + 1'b1;
          if (alu_b == OPND_MAX) begin
            alu_a <= alu_a + 1'b1;
            if (alu_a == OPND_MAX) alu_signal <= next_op(alu_signal);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_bist_seq.sv
// Scoreboard bench for alu_bist_seq: two instances (SETTLE=1 and SETTLE=3), each
// driving a behavioural ALU with injectable faults; a monitor checks every sweep.
module tb_alu_bist_seq;

  localparam int NVEC    = 5 * 256;
  localparam int F_NONE  = 0;
  localparam int F_STUCK = 1;
  localparam int F_SLTU  = 2;
  localparam int F_ONE   = 3;

  typedef struct {
    int kind; int op; int bitn; int val; int a; int b; int mask;
  } fault_t;

  typedef struct {
    int d; int err; int pass; int fsig; int fa; int fb; int cycles;
  } exp_t;

  logic        clk;
  logic        rst[2];
  logic        start[2];
  logic [3:0]  alu_a[2];
  logic [3:0]  alu_b[2];
  logic [2:0]  alu_signal[2];
  logic [3:0]  alu_out[2];
  logic        busy[2];
  logic        done[2];
  logic        pass[2];
  logic [15:0] err_count[2];
  logic [2:0]  fail_signal[2];
  logic [3:0]  fail_a[2];
  logic [3:0]  fail_b[2];

  fault_t flt[2];
  exp_t   exp_q[$];
  int     n_chk = 0;
  int     n_pass = 0;
  int     ops[5] = '{0, 1, 2, 6, 7};
  int     settle_of[2] = '{1, 3};

  alu_bist_seq #(.WIDTH(4), .SETTLE(1), .ERRW(16)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_signal(alu_signal[0]), .alu_out(alu_out[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .fail_signal(fail_signal[0]), .fail_a(fail_a[0]), .fail_b(fail_b[0])
  );

  alu_bist_seq #(.WIDTH(4), .SETTLE(3), .ERRW(16)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_signal(alu_signal[1]), .alu_out(alu_out[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .fail_signal(fail_signal[1]), .fail_a(fail_a[1]), .fail_b(fail_b[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sgn4(int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic int golden(int op, int a, int b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return (a + b) % 16;
      6:       return (a - b + 16) % 16;
      7:       return (sgn4(a) < sgn4(b)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int faulty(int op, int a, int b, fault_t f);
    int r;
    r = golden(op, a, b);
    if (f.kind == F_STUCK && op == f.op)
      r = (f.val != 0) ? (r | (1 << f.bitn)) : (r & ~(1 << f.bitn));
    else if (f.kind == F_SLTU && op == 7)
      r = (a < b) ? 1 : 0;
    else if (f.kind == F_ONE && op == f.op && a == f.a && b == f.b)
      r = r ^ f.mask;
    return r;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++)
      alu_out[d] = 4'(faulty(int'(alu_signal[d]), int'(alu_a[d]), int'(alu_b[d]), flt[d]));
  end

  function automatic exp_t ref_sweep(int d, fault_t f);
    exp_t e;
    e = '{d, 0, 0, 0, 0, 0, NVEC * (settle_of[d] + 1)};
    for (int i = 0; i < 5; i++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          if (faulty(ops[i], a, b, f) != golden(ops[i], a, b)) begin
            if (e.err == 0) begin
              e.fsig = ops[i]; e.fa = a; e.fb = b;
            end
            e.err++;
          end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  function automatic exp_t mk_exp(int d, int err, int fsig, int fa, int fb);
    exp_t e;
    e = '{d, err, (err == 0) ? 1 : 0, fsig, fa, fb, NVEC * (settle_of[d] + 1)};
    return e;
  endfunction

  task automatic chk(string name, longint act, longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  // Monitor: tracks the presented vector sequence and pops the scoreboard on done.
  initial begin
    int   vidx[2], hold[2], vbad[2], cyc[2], pv[2];
    logic busy_p[2], done_p[2];
    int   cv, s;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      vidx[d] = 0; hold[d] = 0; vbad[d] = 0; cyc[d] = 0; pv[d] = 0;
      busy_p[d] = 1'b0; done_p[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        s  = settle_of[d];
        cv = int'({alu_signal[d], alu_a[d], alu_b[d]});
        if (busy[d] === 1'b1) begin
          if (busy_p[d] !== 1'b1) begin
            vidx[d] = 0; hold[d] = 1; cyc[d] = 1;
            vbad[d] = (cv != 0) ? 1 : 0;
          end else begin
            cyc[d]++;
            if (cv == pv[d]) hold[d]++;
            else begin
              if (hold[d] != s + 1) vbad[d]++;
              vidx[d]++;
              if (vidx[d] >= NVEC || cv != (ops[vidx[d] / 256] * 256 + vidx[d] % 256)) vbad[d]++;
              hold[d] = 1;
            end
          end
        end
        pv[d] = cv;
        if (done[d] === 1'b1 && done_p[d] !== 1'b1) begin
          chk("done_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("exp_dut", d, e.d);
            chk("err_count", err_count[d], e.err);
            chk("pass", pass[d], e.pass);
            chk("fail_signal", fail_signal[d], e.fsig);
            chk("fail_a", fail_a[d], e.fa);
            chk("fail_b", fail_b[d], e.fb);
            chk("busy_cycles", cyc[d], e.cycles);
            chk("vec_order_errs", vbad[d], 0);
            chk("vec_last_index", vidx[d], NVEC - 1);
            chk("vec_last_hold", hold[d], s + 1);
          end
        end
        busy_p[d] = busy[d];
        done_p[d] = done[d];
      end
    end
  end

  task automatic pulse_start(int d);
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
  endtask

  task automatic wait_done(int d);
    int k;
    int budget;
    budget = NVEC * (settle_of[d] + 1) + 50;
    k = 0;
    while (done[d] !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", done[d], 1);
  endtask

  task automatic reset_check(int d);
    chk("rst_alu_a", alu_a[d], 0);
    chk("rst_alu_b", alu_b[d], 0);
    chk("rst_alu_signal", alu_signal[d], 0);
    chk("rst_busy", busy[d], 0);
    chk("rst_done", done[d], 0);
    chk("rst_pass", pass[d], 0);
    chk("rst_err_count", err_count[d], 0);
    chk("rst_fail_signal", fail_signal[d], 0);
    chk("rst_fail_a", fail_a[d], 0);
    chk("rst_fail_b", fail_b[d], 0);
  endtask

  function automatic fault_t rand_fault();
    fault_t f;
    f = '{F_NONE, 0, 0, 0, 0, 0, 0};
    f.op = ops[$urandom_range(0, 4)];
    if ($urandom_range(0, 1) == 0) begin
      f.kind = F_STUCK;
      f.bitn = $urandom_range(0, 3);
      f.val  = $urandom_range(0, 1);
    end else begin
      f.kind = F_ONE;
      f.a    = $urandom_range(0, 15);
      f.b    = $urandom_range(0, 15);
      f.mask = $urandom_range(1, 15);
    end
    return f;
  endfunction

  initial begin
    fault_t none_f, f;
    exp_t   e;
    none_f = '{F_NONE, 0, 0, 0, 0, 0, 0};
    flt[0] = none_f; flt[1] = none_f;
    rst[0] = 1'b1; rst[1] = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(negedge clk);
    reset_check(0);
    reset_check(1);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // ADD result bit0 stuck at 0
    flt[0] = '{F_STUCK, 2, 0, 0, 0, 0, 0};
    exp_q.push_back(mk_exp(0, 128, 2, 0, 1));
    pulse_start(0);
    chk("start_busy", busy[0], 1);
    wait_done(0);

    // SLT as unsigned compare, restarted from DONE: results must clear
    flt[0] = '{F_SLTU, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(mk_exp(0, 128, 7, 0, 8));
    pulse_start(0);
    chk("restart_err_clr", err_count[0], 0);
    chk("restart_fail_sig_clr", fail_signal[0], 0);
    chk("restart_fail_b_clr", fail_b[0], 0);
    chk("restart_done_clr", done[0], 0);
    chk("restart_busy", busy[0], 1);
    wait_done(0);

    // start pulsed repeatedly while busy must not restart the sweep
    flt[0] = none_f;
    exp_q.push_back(ref_sweep(0, flt[0]));
    pulse_start(0);
    repeat (8) begin
      repeat ($urandom_range(20, 250)) @(negedge clk);
      pulse_start(0);
    end
    wait_done(0);

    // rst mid-sweep aborts; then a clean sweep
    pulse_start(0);
    repeat (498) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    reset_check(0);
    rst[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_rst_busy", busy[0], 0);
    chk("idle_after_rst_alu_b", alu_b[0], 0);
    exp_q.push_back(ref_sweep(0, flt[0]));
    pulse_start(0);
    wait_done(0);

    // start held through DONE restarts immediately
    flt[0] = rand_fault();
    e = ref_sweep(0, flt[0]);
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(negedge clk); start[0] = 1'b1;
    repeat (2) @(negedge clk);
    wait_done(0);
    repeat (50) @(negedge clk);
    chk("held_restart_busy", busy[0], 1);
    start[0] = 1'b0;
    wait_done(0);

    // randomized faults
    repeat (3) begin
      flt[0] = rand_fault();
      exp_q.push_back(ref_sweep(0, flt[0]));
      pulse_start(0);
      wait_done(0);
    end

    // SETTLE=3 instance: clean sweep then a random fault
    exp_q.push_back(ref_sweep(1, flt[1]));
    pulse_start(1);
    wait_done(1);
    f = rand_fault();
    flt[1] = f;
    exp_q.push_back(ref_sweep(1, f));
    pulse_start(1);
    wait_done(1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
